// File: rtl/block_scheduler_if.sv
// rtl/block_scheduler_if.sv - control, status and per-core signal bundle for block_scheduler
interface block_scheduler_if #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 16,
    parameter int BLOCK_ID_BITS     = 16
);
    localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;

    logic                                start;
    logic                                abort;
    logic [THREAD_COUNT_BITS-1:0]        thread_count;
    logic [NUM_CORES-1:0]                core_done;
    logic [NUM_CORES-1:0]                core_start;
    logic [NUM_CORES-1:0]                core_reset;
    logic [NUM_CORES*BLOCK_ID_BITS-1:0]  core_block_id;
    logic [NUM_CORES*TC_BITS-1:0]        core_thread_count;
    logic                                busy;
    logic                                done;
    logic                                aborted;
    logic [BLOCK_ID_BITS-1:0]            blocks_completed;

    modport slave (
        input  start, abort, thread_count, core_done,
        output core_start, core_reset, core_block_id, core_thread_count,
               busy, done, aborted, blocks_completed
    );

    modport master (
        output start, abort, thread_count, core_done,
        input  core_start, core_reset, core_block_id, core_thread_count,
               busy, done, aborted, blocks_completed
    );
endinterface

// File: rtl/block_scheduler.sv
// rtl/block_scheduler.sv - splits a kernel into blocks and dispatches them to whichever core is free
module block_scheduler #(
    parameter int NUM_CORES         = 4,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 16,
    parameter int BLOCK_ID_BITS     = 16
) (
    input  logic               clk,
    input  logic               reset,
    block_scheduler_if.slave   bus
);
    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int TC_BITS  = LOG2_TPB + 1;
    localparam logic [THREAD_COUNT_BITS:0] TPB_M1 = (THREAD_COUNT_BITS+1)'(THREADS_PER_BLOCK - 1);
    localparam logic [TC_BITS-1:0]         TPB_TC = TC_BITS'(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {SL_FREE, SL_LOAD, SL_ACTIVE} slot_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    slot_t                         r_slot     [NUM_CORES];
    slot_t                         w_slot_nxt [NUM_CORES];
    logic [THREAD_COUNT_BITS-1:0]  r_thread_count;
    logic [BLOCK_ID_BITS-1:0]      r_total_blocks;
    logic [BLOCK_ID_BITS-1:0]      r_dispatched;
    logic [BLOCK_ID_BITS-1:0]      r_completed;
    logic                          r_done;
    logic                          r_aborted;
    logic [BLOCK_ID_BITS-1:0]      r_block_id [NUM_CORES];
    logic [TC_BITS-1:0]            r_core_tc  [NUM_CORES];

    logic                          w_accept;
    logic                          w_abort;
    logic                          w_can_dispatch;
    logic                          w_finish;
    logic [NUM_CORES-1:0]          w_active;
    logic [NUM_CORES-1:0]          w_free;
    logic [NUM_CORES-1:0]          w_fin;
    logic [NUM_CORES-1:0]          w_grant;
    logic [BLOCK_ID_BITS-1:0]      w_inc;
    logic [BLOCK_ID_BITS-1:0]      w_completed_sum;
    logic [BLOCK_ID_BITS-1:0]      w_total_new;
    logic [THREAD_COUNT_BITS-1:0]  w_base;
    logic [THREAD_COUNT_BITS-1:0]  w_rem;
    logic [TC_BITS-1:0]            w_dispatch_tc;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_active[i] = (r_slot[i] == SL_ACTIVE);
            w_free[i]   = (r_slot[i] == SL_FREE);
        end
    end

    // Only a running slot can complete; done levels on idle cores are noise.
    assign w_fin = bus.core_done & w_active;

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_inc = w_inc + BLOCK_ID_BITS'(w_fin[i]);
        end
    end

    assign w_completed_sum = r_completed + w_inc;
    assign w_accept        = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_abort         = (r_state == S_RUN) && bus.abort;
    assign w_finish        = (r_state == S_RUN) && (w_completed_sum == r_total_blocks);
    assign w_can_dispatch  = (r_state == S_RUN) && !bus.abort && (r_dispatched < r_total_blocks);
    assign w_total_new     = BLOCK_ID_BITS'(({1'b0, bus.thread_count} + TPB_M1) >> LOG2_TPB);

    // Remaining threads for the block being dispatched; only the last block can be partial.
    assign w_base        = THREAD_COUNT_BITS'(r_dispatched) << LOG2_TPB;
    assign w_rem         = r_thread_count - w_base;
    assign w_dispatch_tc = (r_dispatched == r_total_blocks - 1'b1) ? TC_BITS'(w_rem) : TPB_TC;

    always_comb begin
        w_grant = '0;
        if (w_can_dispatch) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_free[i] && (w_grant == '0)) begin
                    w_grant[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.thread_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort || w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_slot_nxt[i] = r_slot[i];
            if (w_abort) begin
                w_slot_nxt[i] = SL_FREE;
            end else begin
                case (r_slot[i])
                    SL_FREE:   if (w_grant[i]) w_slot_nxt[i] = SL_LOAD;
                    SL_LOAD:   w_slot_nxt[i] = SL_ACTIVE;
                    SL_ACTIVE: if (bus.core_done[i]) w_slot_nxt[i] = SL_FREE;
                    default:   w_slot_nxt[i] = SL_FREE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_thread_count <= '0;
            r_total_blocks <= '0;
            r_dispatched   <= '0;
            r_completed    <= '0;
            r_done         <= 1'b0;
            r_aborted      <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_slot[i]     <= SL_FREE;
                r_block_id[i] <= '0;
                r_core_tc[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_slot[i] <= w_slot_nxt[i];
                if (w_grant[i]) begin
                    r_block_id[i] <= r_dispatched;
                    r_core_tc[i]  <= w_dispatch_tc;
                end
            end
            if (w_accept) begin
                r_thread_count <= bus.thread_count;
                r_total_blocks <= w_total_new;
                r_dispatched   <= '0;
                r_completed    <= '0;
                r_done         <= (bus.thread_count == '0);
                r_aborted      <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_completed <= w_completed_sum;
                if (w_grant != '0) begin
                    r_dispatched <= r_dispatched + 1'b1;
                end
                if (w_abort) begin
                    r_done    <= 1'b1;
                    r_aborted <= 1'b1;
                end else if (w_finish) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_out
        assign bus.core_start[g]                                   = (r_slot[g] == SL_ACTIVE);
        assign bus.core_reset[g]                                   = (r_slot[g] == SL_FREE);
        assign bus.core_block_id[g*BLOCK_ID_BITS +: BLOCK_ID_BITS] = r_block_id[g];
        assign bus.core_thread_count[g*TC_BITS +: TC_BITS]         = r_core_tc[g];
    end

    assign bus.busy             = (r_state == S_RUN);
    assign bus.done             = r_done;
    assign bus.aborted          = r_aborted;
    assign bus.blocks_completed = r_completed;
endmodule

// File: doc/block_scheduler.md
# block_scheduler

Next-generation kernel block scheduler that sits between the device control register and the compute cores. It splits a kernel of up to 2^THREAD_COUNT_BITS−1 threads into blocks of THREADS_PER_BLOCK and hands each block to whichever core is free, rather than using fixed round-robin waves. Cores finish out of order, and several can finish in the same cycle. The block also supports abort, reports completion progress, and handles a partial last block.

## Interface
- NUM_CORES, 4, number of compute cores driven (≥1)
- THREADS_PER_BLOCK, 4, threads per block; power of two ≥1
- THREAD_COUNT_BITS, 16, width of kernel thread count
- BLOCK_ID_BITS, 16, width of block IDs and counters; must be ≥ THREAD_COUNT_BITS − log2(THREADS_PER_BLOCK) + 1
- TC_BITS (localparam), $clog2(THREADS_PER_BLOCK)+1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  launch request, sampled only in IDLE/DONE
- abort  in  1  kill running kernel, sampled only in RUN
- thread_count  in  THREAD_COUNT_BITS  total threads, latched on accepted start
- core_done  in  NUM_CORES  per-core block-finished level
- core_start  out  NUM_CORES  per-core run enable
- core_reset  out  NUM_CORES  per-core active-high reset to core
- core_block_id  out  NUM_CORES*BLOCK_ID_BITS  flattened, core i at [i*BLOCK_ID_BITS +: BLOCK_ID_BITS]
- core_thread_count  out  NUM_CORES*TC_BITS  flattened, same packing
- busy  out  1  high in RUN
- done  out  1  kernel finished or aborted
- aborted  out  1  last kernel ended by abort
- blocks_completed  out  BLOCK_ID_BITS  blocks finished in current/last kernel

## Operation
- Global FSM: IDLE → RUN → DONE. DONE accepts a new start, exactly as IDLE does.
- Accepted start:
  - latch thread_count;
  - total_blocks = ceil(thread_count / THREADS_PER_BLOCK);
  - clear blocks_dispatched, blocks_completed, done, aborted;
  - go to RUN.
- thread_count == 0: go directly to DONE (done=1) with no core activity.
- Per-core slot FSM: FREE → LOAD → ACTIVE → FREE.
  - FREE: core_reset=1, core_start=0.
  - LOAD (one cycle): core_reset=0, core_start=0; block_id and thread_count are valid.
  - ACTIVE: core_start=1 until core_done[i] is sampled high; the slot is FREE on the next edge.
- Dispatch, in RUN only:
  - while blocks_dispatched < total_blocks, the lowest-index FREE slot enters LOAD with block_id = blocks_dispatched;
  - blocks_dispatched then increments;
  - at most one dispatch per cycle.
- core_thread_count = THREADS_PER_BLOCK, except the last block, which gets thread_count − block_id*THREADS_PER_BLOCK.
- Completion counting:
  - blocks_completed += popcount(core_done & ACTIVE slots) each cycle;
  - core_done on a non-ACTIVE slot is ignored.
- A slot that becomes FREE at edge t is eligible for dispatch at edge t+1 at the earliest.
- RUN → DONE on the edge where blocks_completed + increment == total_blocks. done=1 from that edge onward; done holds until the next accepted start or reset.
- start during RUN is ignored.
- abort in RUN:
  - all slots go FREE on the next edge;
  - state goes to DONE with done=1 and aborted=1;
  - blocks_completed keeps its value, including completions sampled on the abort edge.
- abort is ignored outside RUN. abort and start on the same cycle in IDLE: start wins.
- core_block_id and core_thread_count hold their last value when a slot is FREE.

## Timing
- Reset (reset=0 at an edge) forces:
  - state IDLE, all slots FREE;
  - core_reset = all 1s, core_start = 0;
  - core_block_id = 0, core_thread_count = 0;
  - busy = 0, done = 0, aborted = 0, blocks_completed = 0.
- Reset mid-RUN has the same effect; it overrides start and abort.
- Launch latency, with start sampled at edge E:
  - busy=1 from E;
  - slot 0 in LOAD from E+1;
  - core_start[0] from E+2;
  - slot k (k < total_blocks, all cores free) in LOAD at E+1+k and started at E+2+k.
- Minimum block turnaround on one core: core_done sampled at T → FREE at T+1 → LOAD at T+2 → core_start at T+3.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset hold: reset=0 for 3 cycles, with start=1 → core_reset=4'b1111, core_start=0, done=0, busy=0, blocks_completed=0.
- Partial block: thread_count=10, TPB=4, cores complete after 5 cycles → blocks 0/1/2 on cores 0/1/2 with thread counts 4/4/2; core 3 stays FREE; done=1, blocks_completed=3.
- Oversubscription with out-of-order finish: thread_count=32 (8 blocks), core 2 finishes first → block 4 goes to core 2; core_done on cores 0 and 3 in the same cycle → blocks_completed increments by 2; final done at blocks_completed=8.
- Zero threads: start with thread_count=0 → done=1 one edge after start; no core_start ever asserted.
- Abort: thread_count=64 with abort after 2 completions → next edge core_start=0, core_reset all 1s, done=1, aborted=1, blocks_completed=2; a new start then clears aborted and runs normally.
- Spurious done: core_done[3]=1 while slot 3 is FREE, and start held high during RUN → no count change, no relaunch.
